infoframe_scheduler: RTL and testbench
======================================

// Module: infoframe_scheduler
// PURPOSE
//   Per-slot packet scheduler for HDMI data islands. Shares the single packet slot between one
//   audio-sample stream (highest priority) and NUM_IF infoframe sources (VSIF, AVI, SPD, audio IF).
//   Each enabled infoframe is armed once per video frame and served round-robin. Idle slots get a
//   null packet. Optional per-source checksum insertion into PB0. Sits between the infoframe
//   generators and the data-island packet assembler.
// PARAMETERS
//   NUM_IF         4           number of infoframe sources, 1..8
//   CHECKSUM_MASK  4'b1111     bit i=1: overwrite PB0 of source i with computed checksum
// PORTS
//   clk_pixel      in   1            pixel clock; all logic on rising edge
//   reset          in   1            synchronous, active-high
//   frame_start    in   1            1-cycle pulse, once per video frame
//   packet_enable  in   1            1-cycle pulse: choose content for next packet slot
//   if_enable      in   NUM_IF       per-source enable, sampled at frame_start
//   if_header      in   24*NUM_IF    source i header at [24i+:24]; HB0 = bits [7:0]
//   if_sub         in   224*NUM_IF   source i subpackets at [224i+:224]; sub k at [56k+:56]
//   audio_valid    in   1            audio sample packet available
//   audio_ready    out  1            audio accepted (transfer = valid & ready)
//   audio_header   in   24           audio sample packet header
//   audio_sub      in   224          audio sample subpackets
//   packet_valid   out  1            pulse: packet_header/sub updated this cycle
//   packet_header  out  24           selected header, registered
//   packet_sub     out  224          selected subpackets, registered
//   packet_source  out  4            0..NUM_IF-1 infoframe, 4'hE audio, 4'hF null
//   missed         out  NUM_IF       sticky: source re-armed before being served
// BEHAVIOUR
//   - Reset: pending=0, missed=0, rr_ptr=0, packet_valid=0, audio_ready=0,
//     packet_header=0, packet_sub=0, packet_source=4'hF. Mid-operation reset discards all pending.
//   - frame_start: for each i with if_enable[i]: pending[i]<=1. If pending[i] already 1 and not
//     served this cycle, missed[i]<=1 (held until reset). Disabled sources keep their state.
//   - Selection at cycle t with packet_enable=1, strict priority:
//       1. audio_valid=1 -> audio_ready=1 (combinational, this cycle only), source 4'hE.
//       2. else first pending source searching rr_ptr, rr_ptr+1, ... mod NUM_IF; clear its
//          pending bit; rr_ptr <= (sel+1) mod NUM_IF.
//       3. else null packet: header 24'h0, sub 0, source 4'hF.
//   - audio_ready=0 whenever packet_enable=0; audio never starves infoframes deliberately (caller
//     duty), no aging logic.
//   - Latency 1: packet_header/sub/source registered at t+1 with packet_valid=1 for exactly one
//     cycle; outputs hold value until next packet_enable.
//   - Same-cycle frame_start and serving of source i: pending[i] ends 1 (new instance), missed[i]
//     not set.
//   - packet_enable with no pulse gap (back-to-back): each cycle a valid selection; legal.
//   - Checksum (infoframes with CHECKSUM_MASK[i]=1 only): PB0 = (8'h00 - (HB0+HB1+HB2+PB1..PB27))
//     mod 256, PB n = byte n%7 of sub n/7 (byte j at [8j+:8]). Sum is 8-bit wrap-around; input
//     PB0 ignored. Audio and null packets passed unmodified.
// STRUCTURE
//   - Package hdmi_packet_pkg: packet_header_t (logic[23:0]), packet_sub_t (logic[3:0][55:0]),
//     SRC_AUDIO=4'hE, SRC_NULL=4'hF, type codes 8'h02 audio sample, 8'h81 VSIF, 8'h82 AVI,
//     8'h83 SPD, 8'h84 audio IF.
//   - Sub-module infoframe_checksum (combinational: header+sub in, 8-bit checksum out), one instance
//     on the muxed infoframe path. Round-robin search as a rotate + priority encoder.
// TESTING
//   - Reset: assert reset with pending sources -> next packet_enable yields source 4'hF, zero data.
//   - Checksum: source0 HB=81 01 05, PB1..5=d8 5d c4 01 02, rest 0, PB0 input ff -> output PB0=7d.
//   - Round robin: if_enable=4'b1111, frame_start, 4 packet_enables -> sources 0,1,2,3; 5th -> 4'hF.
//   - Audio priority: audio_valid=1 with pending 2 -> audio_ready pulse, source 4'hE; drop valid ->
//     next enable serves source 2.
//   - Missed: if_enable=4'b0010, two frame_starts with no packet_enable -> missed=4'b0010, sticky.
//   - Collision: frame_start and packet_enable same cycle serving source 1 -> pending[1]=1,
//     missed[1]=0; next enable serves source 1 again.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared types and constants for HDMI data-island packet selection.
// A packet is a 24-bit header plus four 56-bit subpackets.
package hdmi_packet_pkg;

  typedef logic [23:0]      packet_header_t;
  typedef logic [3:0][55:0] packet_sub_t;

  localparam logic [3:0] SRC_AUDIO = 4'hE;
  localparam logic [3:0] SRC_NULL  = 4'hF;

  localparam logic [7:0] TYPE_AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] TYPE_VSIF         = 8'h81;
  localparam logic [7:0] TYPE_AVI          = 8'h82;
  localparam logic [7:0] TYPE_SPD          = 8'h83;
  localparam logic [7:0] TYPE_AUDIO_IF     = 8'h84;

endpackage

// File: rtl/infoframe_checksum.sv
// Combinational infoframe checksum: the byte that makes HB0..HB2 plus PB0..PB27 sum to zero.
// The incoming PB0 is ignored, since it is the byte being replaced.
module infoframe_checksum
  import hdmi_packet_pkg::*;
(
  input  packet_header_t i_header,
  input  packet_sub_t    i_sub,
  output logic [7:0]     o_checksum
);

  logic [7:0] w_sum;

  // PB n lives in byte n%7 of subpacket n/7.
  always_comb begin
    w_sum = i_header[7:0] + i_header[15:8] + i_header[23:16];
    for (int n = 1; n < 28; n++) begin
      w_sum = w_sum + i_sub[n / 7][8 * (n % 7) +: 8];
    end
    o_checksum = 8'h00 - w_sum;
  end

endmodule

// File: rtl/infoframe_scheduler.sv
// Per-slot data-island packet scheduler: audio first, then armed infoframes round-robin,
// otherwise a null packet. The selected packet is registered one cycle after packet_enable.
module infoframe_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int                 NUM_IF        = 4,
  parameter logic [NUM_IF-1:0]  CHECKSUM_MASK = {NUM_IF{1'b1}}
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    packet_enable,
  input  logic [NUM_IF-1:0]       if_enable,
  input  logic [24*NUM_IF-1:0]    if_header,
  input  logic [224*NUM_IF-1:0]   if_sub,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  input  logic [23:0]             audio_header,
  input  logic [223:0]            audio_sub,
  output logic                    packet_valid,
  output logic [23:0]             packet_header,
  output logic [223:0]            packet_sub,
  output logic [3:0]              packet_source,
  output logic [NUM_IF-1:0]       missed
);

  localparam int PW = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;

  logic [NUM_IF-1:0] r_pending;
  logic [NUM_IF-1:0] r_missed;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_valid;
  packet_header_t    r_header;
  packet_sub_t       r_sub;
  logic [3:0]        r_source;

  logic              w_found;
  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_idx;
  logic [PW-1:0]     w_rr_next;
  packet_header_t    w_if_header;
  packet_sub_t       w_if_sub;
  packet_sub_t       w_if_sub_ck;
  logic              w_ck_en;
  logic [7:0]        w_checksum;
  logic              w_serve;
  logic [NUM_IF-1:0] w_served;
  logic [NUM_IF-1:0] w_pending_next;
  logic [NUM_IF-1:0] w_missed_next;

  // Rotated priority search: first pending source starting at r_rr_ptr, wrapping at NUM_IF.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = r_rr_ptr;
    for (int k = 0; k < NUM_IF; k++) begin
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
      w_idx = (w_idx == PW'(NUM_IF - 1)) ? '0 : w_idx + 1'b1;
    end
    w_rr_next = (w_sel == PW'(NUM_IF - 1)) ? '0 : w_sel + 1'b1;
  end

  always_comb begin
    w_if_header = '0;
    w_if_sub    = '0;
    w_ck_en     = 1'b0;
    for (int i = 0; i < NUM_IF; i++) begin
      if (w_sel == PW'(i)) begin
        w_if_header = if_header[24*i +: 24];
        w_if_sub    = if_sub[224*i +: 224];
        w_ck_en     = CHECKSUM_MASK[i];
      end
    end
  end

  infoframe_checksum u_checksum (
    .i_header   (w_if_header),
    .i_sub      (w_if_sub),
    .o_checksum (w_checksum)
  );

  always_comb begin
    w_if_sub_ck = w_if_sub;
    if (w_ck_en) w_if_sub_ck[0][7:0] = w_checksum;
  end

  // A source served in the same cycle it is re-armed keeps the new instance and is not missed.
  always_comb begin
    w_serve  = packet_enable && !audio_valid && w_found;
    w_served = '0;
    for (int i = 0; i < NUM_IF; i++) begin
      w_served[i] = w_serve && (w_sel == PW'(i));
    end
    w_pending_next = (r_pending & ~w_served) | (frame_start ? if_enable : '0);
    w_missed_next  = r_missed | (frame_start ? (if_enable & r_pending & ~w_served) : '0);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_pending <= '0;
      r_missed  <= '0;
      r_rr_ptr  <= '0;
      r_valid   <= 1'b0;
      r_header  <= '0;
      r_sub     <= '0;
      r_source  <= SRC_NULL;
    end else begin
      r_pending <= w_pending_next;
      r_missed  <= w_missed_next;
      r_valid   <= packet_enable;
      if (w_serve) r_rr_ptr <= w_rr_next;
      if (packet_enable) begin
        if (audio_valid) begin
          r_header <= audio_header;
          r_sub    <= audio_sub;
          r_source <= SRC_AUDIO;
        end else if (w_found) begin
          r_header <= w_if_header;
          r_sub    <= w_if_sub_ck;
          r_source <= 4'(w_sel);
        end else begin
          r_header <= '0;
          r_sub    <= '0;
          r_source <= SRC_NULL;
        end
      end
    end
  end

  assign audio_ready   = packet_enable && audio_valid;
  assign packet_valid  = r_valid;
  assign packet_header = r_header;
  assign packet_sub    = r_sub;
  assign packet_source = r_source;
  assign missed        = r_missed;

endmodule

// File: tb/tb_infoframe_scheduler.sv
// Directed bench for infoframe_scheduler: reset, checksum, round robin, audio priority,
// missed flags and the frame_start/serve collision.
module tb_infoframe_scheduler;

  logic         clk_pixel = 1'b0;
  logic         reset;
  logic         frame_start;
  logic         packet_enable;
  logic [3:0]   if_enable;
  logic [95:0]  if_header;
  logic [895:0] if_sub;
  logic         audio_valid;
  logic         audio_ready;
  logic [23:0]  audio_header;
  logic [223:0] audio_sub;
  logic         packet_valid;
  logic [23:0]  packet_header;
  logic [223:0] packet_sub;
  logic [3:0]   packet_source;
  logic [3:0]   missed;

  int total = 0;
  int bad   = 0;

  always #5 clk_pixel = ~clk_pixel;

  infoframe_scheduler dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .frame_start   (frame_start),
    .packet_enable (packet_enable),
    .if_enable     (if_enable),
    .if_header     (if_header),
    .if_sub        (if_sub),
    .audio_valid   (audio_valid),
    .audio_ready   (audio_ready),
    .audio_header  (audio_header),
    .audio_sub     (audio_sub),
    .packet_valid  (packet_valid),
    .packet_header (packet_header),
    .packet_sub    (packet_sub),
    .packet_source (packet_source),
    .missed        (missed)
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Infoframe sub images: source 0 carries the reference payload, others only a junk PB0.
  localparam logic [223:0] SUB0_IN  = {168'h0, 56'h000201c45dd8ff};
  localparam logic [223:0] SUB0_OUT = {168'h0, 56'h000201c45dd87d};
  localparam logic [223:0] SUBX_IN  = {168'h0, 56'h000000000000aa};
  localparam logic [223:0] AUD_SUB  = {32'hdeadbeef, 192'h0, 8'h5a, 48'h0123456789ab, 8'h00, 56'h0};

  initial begin
    reset         = 1'b1;
    frame_start   = 1'b0;
    packet_enable = 1'b0;
    if_enable     = 4'b0000;
    audio_valid   = 1'b0;
    audio_header  = 24'h000002;
    audio_sub     = AUD_SUB;
    if_header     = {24'h0A0184, 24'h190183, 24'h0D0282, 24'h050181};
    if_sub        = {SUBX_IN, SUBX_IN, SUBX_IN, SUB0_IN};
    tick();
    tick();
    check("rst_valid", 224'(packet_valid), 224'(1'b0));
    check("rst_source", 224'(packet_source), 224'(4'hF));
    check("rst_missed", 224'(missed), 224'(4'b0000));
    check("rst_ready", 224'(audio_ready), 224'(1'b0));
    reset = 1'b0;

    // Arm everything, then reset mid-operation: the pending work must vanish.
    if_enable   = 4'b1111;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    reset       = 1'b1;
    tick();
    reset         = 1'b0;
    packet_enable = 1'b1;
    tick();
    check("rstpend_valid", 224'(packet_valid), 224'(1'b1));
    check("rstpend_source", 224'(packet_source), 224'(4'hF));
    check("rstpend_header", 224'(packet_header), 224'(24'h0));
    check("rstpend_sub", packet_sub, 224'h0);
    packet_enable = 1'b0;
    tick();
    check("rstpend_pulse", 224'(packet_valid), 224'(1'b0));

    // Round robin over all four sources with back-to-back enables.
    frame_start = 1'b1;
    tick();
    frame_start   = 1'b0;
    packet_enable = 1'b1;
    tick();
    check("rr0_source", 224'(packet_source), 224'(4'h0));
    check("rr0_header", 224'(packet_header), 224'(24'h050181));
    check("rr0_checksum", packet_sub, SUB0_OUT);
    tick();
    check("rr1_source", 224'(packet_source), 224'(4'h1));
    check("rr1_checksum", packet_sub, {168'h0, 56'h6f});
    tick();
    check("rr2_source", 224'(packet_source), 224'(4'h2));
    check("rr2_checksum", packet_sub, {168'h0, 56'h63});
    tick();
    check("rr3_source", 224'(packet_source), 224'(4'h3));
    check("rr3_header", 224'(packet_header), 224'(24'h0A0184));
    check("rr3_checksum", packet_sub, {168'h0, 56'h71});
    tick();
    check("rr4_source", 224'(packet_source), 224'(4'hF));
    check("rr4_valid", 224'(packet_valid), 224'(1'b1));
    packet_enable = 1'b0;
    tick();
    check("rr_hold_valid", 224'(packet_valid), 224'(1'b0));
    check("rr_hold_source", 224'(packet_source), 224'(4'hF));

    // Audio beats a pending infoframe; the infoframe follows once audio drops.
    if_enable   = 4'b0100;
    frame_start = 1'b1;
    tick();
    frame_start   = 1'b0;
    audio_valid   = 1'b1;
    packet_enable = 1'b1;
    #1;
    check("aud_ready_hi", 224'(audio_ready), 224'(1'b1));
    tick();
    check("aud_source", 224'(packet_source), 224'(4'hE));
    check("aud_header", 224'(packet_header), 224'(24'h000002));
    check("aud_sub", packet_sub, AUD_SUB);
    packet_enable = 1'b0;
    #1;
    check("aud_ready_lo", 224'(audio_ready), 224'(1'b0));
    tick();
    audio_valid   = 1'b0;
    packet_enable = 1'b1;
    tick();
    check("aud_after_source", 224'(packet_source), 224'(4'h2));
    packet_enable = 1'b0;
    tick();

    // Re-arming an unserved source raises a sticky missed flag.
    if_enable   = 4'b0010;
    frame_start = 1'b1;
    tick();
    check("miss_first", 224'(missed), 224'(4'b0000));
    tick();
    check("miss_set", 224'(missed), 224'(4'b0010));
    frame_start   = 1'b0;
    packet_enable = 1'b1;
    tick();
    check("miss_serve_source", 224'(packet_source), 224'(4'h1));
    packet_enable = 1'b0;
    tick();
    check("miss_sticky", 224'(missed), 224'(4'b0010));

    // Collision: serving source 1 while it is re-armed keeps one new instance, no miss.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("col_rst_missed", 224'(missed), 224'(4'b0000));
    frame_start = 1'b1;
    tick();
    packet_enable = 1'b1;
    tick();
    check("col_source", 224'(packet_source), 224'(4'h1));
    check("col_missed", 224'(missed), 224'(4'b0000));
    frame_start = 1'b0;
    tick();
    check("col_again_source", 224'(packet_source), 224'(4'h1));
    tick();
    check("col_empty_source", 224'(packet_source), 224'(4'hF));
    packet_enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
